// File: rtl/ncl_pkg.sv
// Shared NCL definitions: completion phase encoding and a popcount helper.
package ncl_pkg;

  // Widest gate the popcount helper accepts; narrower inputs are zero-extended.
  localparam int POP_MAX = 32;

  typedef enum logic {
    PH_NULL = 1'b0,
    PH_DATA = 1'b1
  } ncl_phase_e;

  // Number of ones in v; callers zero-extend their N-bit rail to POP_MAX.
  function automatic logic [31:0] popcount(input logic [POP_MAX-1:0] v);
    logic [31:0] n;
    n = '0;
    for (int i = 0; i < POP_MAX; i++) n = n + 32'(v[i]);
    return n;
  endfunction

endpackage

// File: rtl/ncl_thmn_bank_if.sv
// Bank-level bus: gate inputs and error clear in, gate outputs and completion out.
interface ncl_thmn_bank_if #(
  parameter int CH    = 4,
  parameter int N     = 2,
  parameter int CNT_W = 8
);
  logic [CH*N-1:0]  a;
  logic             err_clr;
  logic [CH-1:0]    y;
  logic             ko;
  logic [CNT_W-1:0] data_cnt;
  logic             err;

  modport master (output a, err_clr, input y, ko, data_cnt, err);
  modport slave  (input a, err_clr, output y, ko, data_cnt, err);
endinterface

// File: rtl/ncl_thmn_cell.sv
// One THmn gate with hysteresis: sets at >= M inputs high, clears only when all low.
module ncl_thmn_cell
  import ncl_pkg::*;
#(
  parameter int N   = 2,
  parameter int M   = 1,
  parameter bit INV = 1'b0
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic [N-1:0] a,
  output logic         state,
  output logic         y
);

  if (M < 1 || M > N || N > POP_MAX) begin : g_bad_param
    $error("ncl_thmn_cell: need 1 <= M <= N <= 32");
  end

  localparam logic [31:0] M_U = 32'(M);

  logic [31:0] k;
  assign k = popcount(POP_MAX'(a));

  // Threshold reached sets, full NULL clears, anything in between holds.
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n)         state <= 1'b0;
    else if (k >= M_U)  state <= 1'b1;
    else if (k == '0)   state <= 1'b0;

  // Output polarity is a static inversion of the registered state.
  assign y = state ^ INV;

endmodule

// File: rtl/ncl_thmn_bank.sv
// Bank of CH THmn gates with a registered completion detector, DATA counter and
// sticky protocol-violation flag.
module ncl_thmn_bank
  import ncl_pkg::*;
#(
  parameter int CH    = 4,
  parameter int N     = 2,
  parameter int M     = 1,
  parameter bit INV   = 1'b0,
  parameter int CNT_W = 8
) (
  input  logic              clk,
  input  logic              rst_n,
  ncl_thmn_bank_if.slave    bus
);

  logic [CH-1:0]    st;
  logic [CH-1:0]    any_hi;
  ncl_phase_e       ph;
  logic             ko_q;
  logic [CNT_W-1:0] cnt_q;
  logic             err_q;
  logic             early;
  logic             orphan;

  for (genvar c = 0; c < CH; c++) begin : g_ch
    ncl_thmn_cell #(.N(N), .M(M), .INV(INV)) u_cell (
      .clk   (clk),
      .rst_n (rst_n),
      .a     (bus.a[c*N +: N]),
      .state (st[c]),
      .y     (bus.y[c])
    );
    assign any_hi[c] = |bus.a[c*N +: N];
  end

  // New DATA on a channel that already returned to NULL before the bank did.
  assign early  = (ph == PH_DATA) && |(~st & any_hi);
  // A set channel dropping back to NULL while the DATA wavefront is incomplete.
  assign orphan = (ph == PH_NULL) && |(st & ~any_hi) && |(~st);

  // Completion FSM: flips on full-bank DATA / full-bank NULL, counts DATA wavefronts.
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      ph    <= PH_NULL;
      ko_q  <= 1'b1;
      cnt_q <= '0;
    end else begin
      case (ph)
        PH_NULL: if (&st) begin
          ph    <= PH_DATA;
          ko_q  <= 1'b0;
          cnt_q <= cnt_q + CNT_W'(1);
        end
        PH_DATA: if (~|st) begin
          ph   <= PH_NULL;
          ko_q <= 1'b1;
        end
        default: begin
          ph   <= PH_NULL;
          ko_q <= 1'b1;
        end
      endcase
    end

  // Sticky error; a violation in the same cycle as a clear keeps it set.
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n)               err_q <= 1'b0;
    else if (early || orphan) err_q <= 1'b1;
    else if (bus.err_clr)     err_q <= 1'b0;

  assign bus.ko       = ko_q;
  assign bus.data_cnt = cnt_q;
  assign bus.err      = err_q;

endmodule

// File: tb/tb_ncl_thmn_bank.sv
// Scoreboard bench: stimulus pushes time-tagged expectations, a negedge monitor
// pops and compares them against four differently parameterised banks.
module tb_ncl_thmn_bank;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  ncl_thmn_bank_if #(.CH(4), .N(2), .CNT_W(8)) bus0 ();
  ncl_thmn_bank_if #(.CH(4), .N(2), .CNT_W(8)) bus1 ();
  ncl_thmn_bank_if #(.CH(1), .N(3), .CNT_W(8)) bus2 ();
  ncl_thmn_bank_if #(.CH(1), .N(2), .CNT_W(8)) bus3 ();

  ncl_thmn_bank #(.CH(4), .N(2), .M(1), .INV(1'b0), .CNT_W(8)) dut0 (.clk(clk), .rst_n(rst_n), .bus(bus0));
  ncl_thmn_bank #(.CH(4), .N(2), .M(1), .INV(1'b1), .CNT_W(8)) dut1 (.clk(clk), .rst_n(rst_n), .bus(bus1));
  ncl_thmn_bank #(.CH(1), .N(3), .M(2), .INV(1'b0), .CNT_W(8)) dut2 (.clk(clk), .rst_n(rst_n), .bus(bus2));
  ncl_thmn_bank #(.CH(1), .N(2), .M(2), .INV(1'b0), .CNT_W(8)) dut3 (.clk(clk), .rst_n(rst_n), .bus(bus3));

  localparam int Y = 0, KO = 1, CNT = 2, ERR = 3;

  typedef struct {
    int unsigned cyc;
    int          d;
    int          sel;
    logic [31:0] exp;
    string       nm;
  } exp_t;

  exp_t        sb[$];
  int unsigned cyc = 0;
  int          n_chk = 0;
  int          n_fail = 0;

  always @(posedge clk) cyc <= cyc + 1;

  function automatic logic [31:0] actual(input int d, input int sel);
    logic [31:0] r;
    r = '0;
    case (d)
      0: case (sel) Y: r = 32'(bus0.y); KO: r = 32'(bus0.ko); CNT: r = 32'(bus0.data_cnt); default: r = 32'(bus0.err); endcase
      1: case (sel) Y: r = 32'(bus1.y); KO: r = 32'(bus1.ko); CNT: r = 32'(bus1.data_cnt); default: r = 32'(bus1.err); endcase
      2: case (sel) Y: r = 32'(bus2.y); KO: r = 32'(bus2.ko); CNT: r = 32'(bus2.data_cnt); default: r = 32'(bus2.err); endcase
      default: case (sel) Y: r = 32'(bus3.y); KO: r = 32'(bus3.ko); CNT: r = 32'(bus3.data_cnt); default: r = 32'(bus3.err); endcase
    endcase
    return r;
  endfunction

  // Expect value v on (d, sel) after lat more rising edges.
  task automatic chk(input int d, input int sel, input logic [31:0] v, input string nm, input int lat);
    exp_t e;
    e.cyc = cyc + lat;
    e.d   = d;
    e.sel = sel;
    e.exp = v;
    e.nm  = nm;
    sb.push_back(e);
  endtask

  task automatic step();
    @(negedge clk);
  endtask

  // Monitor: on each falling edge compare every expectation due by now.
  initial begin
    exp_t        e;
    logic [31:0] act;
    int          i;
    forever begin
      @(negedge clk);
      i = 0;
      while (i < sb.size()) begin
        if (sb[i].cyc <= cyc) begin
          e = sb[i];
          sb.delete(i);
          act = actual(e.d, e.sel);
          n_chk++;
          if (e.cyc < cyc) begin
            n_fail++;
            $display("FAIL %s: sample slot %0d missed at cycle %0d", e.nm, e.cyc, cyc);
          end else if (act !== e.exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", e.nm, act, e.exp, cyc);
          end
        end else begin
          i++;
        end
      end
    end
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish, %0d expectations pending", sb.size());
    $fatal(1, "watchdog");
  end

  initial begin
    bus0.a = '1; bus1.a = '1; bus2.a = '1; bus3.a = '1;
    bus0.err_clr = 1'b0; bus1.err_clr = 1'b0; bus2.err_clr = 1'b0; bus3.err_clr = 1'b0;
    rst_n = 1'b0;

    // Reset with all inputs high: outputs stay at reset values.
    step();
    chk(0, Y, 32'h0, "rst_y", 1);
    chk(0, KO, 32'h1, "rst_ko", 1);
    chk(0, CNT, 32'h0, "rst_cnt", 1);
    chk(0, ERR, 32'h0, "rst_err", 1);
    chk(1, Y, 32'hF, "rst_y_inv", 1);
    step(); step();
    bus0.a = '0; bus1.a = '0; bus2.a = '0; bus3.a = '0;
    rst_n = 1'b1;
    step();

    // Hysteresis, N=3 M=2.
    bus2.a = 3'b011; chk(2, Y, 32'h1, "hys_set", 1); chk(2, KO, 32'h0, "hys_ko_fall", 2); chk(2, CNT, 32'h1, "hys_cnt", 2); step();
    bus2.a = 3'b001; chk(2, Y, 32'h1, "hys_hold1", 1); step();
    bus2.a = 3'b000; chk(2, Y, 32'h0, "hys_clr", 1); chk(2, KO, 32'h1, "hys_ko_rise", 2); step();
    step();
    bus2.a = 3'b001; chk(2, Y, 32'h0, "hys_hold0", 1); step();
    bus2.a = 3'b000; step();

    // C-element, N=M=2.
    bus3.a = 2'b01; chk(3, Y, 32'h0, "cel_01", 1); step();
    bus3.a = 2'b11; chk(3, Y, 32'h1, "cel_11", 1); step();
    bus3.a = 2'b10; chk(3, Y, 32'h1, "cel_10_hold", 1); step();
    bus3.a = 2'b00; chk(3, Y, 32'h0, "cel_00", 1); step();

    // Inverted output.
    bus1.a = 8'h55; chk(1, Y, 32'h0, "inv_data", 1); step();
    bus1.a = 8'h00; chk(1, Y, 32'hF, "inv_null", 1); step(); step();

    // Full wavefronts, 256 of them to wrap the counter.
    for (int w = 1; w <= 256; w++) begin
      bus0.a = 8'h55;
      if (w == 1) begin
        chk(0, Y, 32'hF, "wf_y_data", 1);
        chk(0, KO, 32'h0, "wf_ko_fall", 2);
      end
      if (w == 1 || w == 2 || w == 255 || w == 256)
        chk(0, CNT, 32'(w % 256), $sformatf("wf_cnt_%0d", w), 2);
      step();
      bus0.a = 8'h00;
      if (w == 1) begin
        chk(0, Y, 32'h0, "wf_y_null", 1);
        chk(0, KO, 32'h1, "wf_ko_rise", 2);
      end
      step(); step();
    end
    chk(0, ERR, 32'h0, "wf_no_err", 1);
    chk(0, CNT, 32'h0, "wf_cnt_wrap", 1);
    step();

    // Early DATA: channel 0 returns to NULL then re-asserts while the bank is DATA.
    bus0.a = 8'h55; step(); step();
    bus0.a = 8'h54; step();
    bus0.a = 8'h56; chk(0, ERR, 32'h1, "early_err", 1); chk(0, KO, 32'h0, "early_ko", 1); step();
    bus0.err_clr = 1'b1; chk(0, ERR, 32'h0, "early_clr", 1); step();
    bus0.err_clr = 1'b0; bus0.a = 8'h00; step(); step(); step();

    // Orphan withdrawal, then clear colliding with a fresh violation.
    bus0.a = 8'h05; step();
    bus0.a = 8'h04; chk(0, ERR, 32'h1, "orphan_err", 1); step();
    bus0.a = 8'h00; bus0.err_clr = 1'b1; chk(0, ERR, 32'h1, "set_wins", 1); step();
    chk(0, ERR, 32'h0, "orphan_clr", 1); step();
    bus0.err_clr = 1'b0; step();

    // Asynchronous reset mid-wavefront.
    bus0.a = 8'h05; chk(0, Y, 32'h3, "mid_y_pre", 1); chk(0, CNT, 32'h1, "mid_cnt_pre", 1); step();
    @(posedge clk);
    #2 rst_n = 1'b0;
    chk(0, Y, 32'h0, "async_y", 0);
    chk(0, KO, 32'h1, "async_ko", 0);
    chk(0, CNT, 32'h0, "async_cnt", 0);
    chk(0, ERR, 32'h0, "async_err", 0);
    chk(1, Y, 32'hF, "async_y_inv", 0);
    #2 rst_n = 1'b1;
    step();
    bus0.a = 8'h55; chk(0, Y, 32'hF, "restart_y", 1); chk(0, KO, 32'h0, "restart_ko", 2); chk(0, CNT, 32'h1, "restart_cnt", 2); step();
    bus0.a = 8'h00; chk(0, Y, 32'h0, "restart_null", 1); chk(0, KO, 32'h1, "restart_ko_rise", 2); chk(0, ERR, 32'h0, "restart_err", 2); step();
    step(); step();

    // Drain the scoreboard with a bounded wait.
    for (int t = 0; t < 20 && sb.size() > 0; t++) step();
    if (sb.size() > 0) begin
      n_fail += sb.size();
      $display("FAIL drain: %0d expectations never sampled", sb.size());
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
